// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper move controller: step-mode and FSM
// encodings plus the 8-entry coil phase table (A..D on bits 3..0).
package stepper_pkg;

  typedef enum logic [1:0] {
    MODE_WAVE = 2'b00,
    MODE_FULL = 2'b01,
    MODE_HALF = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Entry i lives in bits [4*i +: 4]; entry 0 is the least significant nibble.
  localparam logic [31:0] PHASE_TABLE = {
    4'b1001,  // 7
    4'b0001,  // 6
    4'b0011,  // 5
    4'b0010,  // 4
    4'b0110,  // 3
    4'b0100,  // 2
    4'b1100,  // 1
    4'b1000   // 0
  };

  function automatic logic [3:0] phase_coils(input logic [2:0] idx);
    return PHASE_TABLE[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/stepper_tick_gen.sv
// Step-rate divider: counts clk cycles while enabled and raises tick on the
// cycle where the count reaches period-1, then wraps to zero.
module stepper_tick_gen #(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // period is always at least 1 here, so period-1 never underflows.
  assign tick = en && (cnt_q == (period - DIV_W'(1)));

  // Next count: clear on request, wrap on tick, otherwise count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stepper_move_ctrl.sv
// Stepper motor move controller: accepts a move (direction, mode, step count,
// step period), sequences the coil phase table and tracks signed position.
// Optional build macro STEPPER_HOLD_EN keeps the last phase energised while
// idle (holding torque) once any move has been accepted since reset.
module stepper_move_ctrl
  import stepper_pkg::*;
#(
  parameter int DIV_W = 20,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             direcc,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] period,
  output logic [3:0]       bobinasMotor,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ledDirecc,
  output logic [CNT_W-1:0] pos
);

  state_e           state_q,  state_d;
  logic [2:0]       idx_q,    idx_d;
  logic [CNT_W-1:0] pos_q,    pos_d;
  logic [CNT_W-1:0] rem_q,    rem_d;
  logic             dir_q,    dir_d;
  mode_e            mode_q,   mode_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [3:0]       coils_q,  coils_d;
  logic             done_q,   done_d;
  logic             err_q,    err_d;
  logic             led_q,    led_d;
  logic             moved_q,  moved_d;
  logic             clr_s;
  logic             tick_s;
  logic [2:0]       stride_s;

  stepper_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == ST_RUN),
    .clr    (clr_s),
    .period (period_q),
    .tick   (tick_s)
  );

  // Phase stride per step: half stepping walks every entry, others skip one.
  always_comb begin
    if (mode_q == MODE_HALF) begin
      stride_s = 3'd1;
    end else begin
      stride_s = 3'd2;
    end
  end

  // Move sequencing: acceptance, stepping, stop/abort and completion.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pos_d    = pos_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    period_d = period_q;
    moved_d  = moved_q;
    led_d    = led_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    clr_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mode == MODE_RSVD) begin
            err_d = 1'b1;
          end else begin
            dir_d    = direcc;
            led_d    = direcc;
            mode_d   = mode_e'(mode);
            period_d = (period == '0) ? DIV_W'(1) : period;
            clr_s    = 1'b1;
            if (steps == '0) begin
              // Zero-length move completes at once and leaves the coils alone.
              done_d = 1'b1;
            end else begin
              rem_d   = steps;
              moved_d = 1'b1;
              state_d = ST_RUN;
              case (mode_e'(mode))
                MODE_WAVE: idx_d = {idx_q[2:1], 1'b0};
                MODE_FULL: idx_d = {idx_q[2:1], 1'b1};
                default:   idx_d = idx_q;
              endcase
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          // Abort wins over a coinciding step; position and phase are kept.
          state_d = ST_IDLE;
        end else if (tick_s) begin
          if (dir_q) begin
            idx_d = idx_q + stride_s;
            pos_d = pos_q + CNT_W'(1);
          end else begin
            idx_d = idx_q - stride_s;
            pos_d = pos_q - CNT_W'(1);
          end
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Coil drive derived from next state so the output register lines up with it.
  always_comb begin
`ifdef STEPPER_HOLD_EN
    if ((state_d == ST_RUN) || moved_d) begin
      coils_d = phase_coils(idx_d);
    end else begin
      coils_d = 4'b0000;
    end
`else
    if (state_d == ST_RUN) begin
      coils_d = phase_coils(idx_d);
    end else begin
      coils_d = 4'b0000;
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 3'd0;
      pos_q    <= '0;
      rem_q    <= '0;
      dir_q    <= 1'b0;
      mode_q   <= MODE_WAVE;
      period_q <= DIV_W'(1);
      coils_q  <= 4'b0000;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      led_q    <= 1'b0;
      moved_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pos_q    <= pos_d;
      rem_q    <= rem_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      coils_q  <= coils_d;
      done_q   <= done_d;
      err_q    <= err_d;
      led_q    <= led_d;
      moved_q  <= moved_d;
    end
  end

  assign bobinasMotor = coils_q;
  assign busy         = (state_q == ST_RUN);
  assign done         = done_q;
  assign err          = err_q;
  assign ledDirecc    = led_q;
  assign pos          = pos_q;

endmodule
